// File: rtl/logit_accumulator.sv
// logit_accumulator: per-class signed score accumulator feeding argmax; define LOGIT_ACC_SAT_EN for saturating sums
module logit_accumulator #(
  parameter int IN_WIDTH   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_STEPS  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           i_ready,
  input  logic [IN_WIDTH-1:0]            i_data,
  input  logic                           i_clear,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [3*DATA_WIDTH-1:0]        o_logits,
  output logic [$clog2(NUM_STEPS+1)-1:0] o_step
);
  localparam int SW = $clog2(NUM_STEPS+1);
  typedef enum logic {ACCUM, OUTPUT} state_t;
  state_t                     state_q;
  logic [2:0][DATA_WIDTH-1:0] acc_q;
  logic [1:0]                 cls_q;
  logic [SW-1:0]              step_q;
  logic signed [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH-1:0]      acc_d;
  logic                       beat, last, restart;
  assign i_ready  = state_q == ACCUM && !i_clear;
  assign beat     = i_valid && i_ready;
  assign last     = cls_q == 2'd2 && step_q == SW'(NUM_STEPS-1);
  assign restart  = i_clear || (state_q == OUTPUT && o_ready);
  assign o_valid  = state_q == OUTPUT;
  assign o_logits = acc_q;
  assign o_step   = step_q;
  always_comb begin
    sum = $signed({acc_q[cls_q][DATA_WIDTH-1], acc_q[cls_q]}) + (DATA_WIDTH+1)'($signed(i_data));
`ifdef LOGIT_ACC_SAT_EN
    acc_d = (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
          ? (sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}})
          : sum[DATA_WIDTH-1:0];
`else
    acc_d = sum[DATA_WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || restart) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cls_q   <= '0;
      step_q  <= '0;
    end else if (beat) begin
      acc_q[cls_q] <= acc_d;
      cls_q        <= cls_q == 2'd2 ? 2'd0 : cls_q + 2'd1;
      if (cls_q == 2'd2) step_q <= step_q + SW'(1);
      if (last) state_q <= OUTPUT;
    end
  end
endmodule
